tt_proj_mux_ctrl: RTL
=====================

Name: tt_proj_mux_ctrl

Overview:
Project-select controller for the shared pad bundle that feeds per-project wrappers. It accepts a project address over a valid/ready handshake and keeps every project's ena low during a guard interval. It then asserts ena for the new project and holds that project's rst_n low for a fixed count before handing it the pads. The input bundle (iw) is broadcast to all wrappers with rst_n gated, and the selected wrapper's output bundle (ow) is returned.

Parameters:
NUM_PROJ, 16, number of attached project wrappers (2..256)
ADDR_W, 4, width of project address; must satisfy 2^ADDR_W >= NUM_PROJ
GUARD_CYCLES, 2, cycles with all ena low between projects (>= 1)
RST_CYCLES, 8, cycles the new project's rst_n is held low after its ena rises (>= 1)

Ports:
clk  input  1  controller clock
rst_n  input  1  synchronous active-low reset
sel_valid  input  1  select request valid
sel_ready  output  1  controller can accept a request
sel_addr  input  ADDR_W  requested project; any value >= NUM_PROJ means deselect all
cur_addr  output  ADDR_W  address of the last accepted request
active  output  1  a project is enabled (RESET or RUN)
running  output  1  a project is out of reset (RUN)
proj_ena  output  NUM_PROJ  one-hot ena, one bit per wrapper
iw_in  input  18  pad bundle {uio_in, ui_in, rst_n, clk}
iw_out  output  18  bundle broadcast to all wrappers
ow_in  input  24*NUM_PROJ  concatenated wrapper outputs; project p occupies bits [24p+23:24p]
ow_out  output  24  selected bundle {uio_oe, uio_out, uo_out}

Behaviour:
- Synchronous reset (rst_n low at a clk edge) forces:
  - state IDLE, cur_addr 0, proj_ena 0, counters 0;
  - active 0, running 0, sel_ready 1.
- Reset applies from any state, including mid-DRAIN and mid-RESET.
- States:
  - IDLE: no project enabled.
  - DRAIN: guard interval.
  - RESET: new project held in reset.
  - RUN: project running.
- sel_ready is 1 in IDLE and RUN and 0 in DRAIN and RESET. It is a combinational decode of the state register.
- A request is accepted at an edge where sel_valid && sel_ready. At that edge:
  - cur_addr <= sel_addr;
  - state <= DRAIN;
  - the guard counter loads GUARD_CYCLES-1.
- DRAIN:
  - proj_ena all 0; the counter decrements each cycle.
  - When the count is 0: if cur_addr < NUM_PROJ, go to RESET and load the reset counter with RST_CYCLES-1; otherwise go to IDLE.
  - DRAIN lasts exactly GUARD_CYCLES cycles.
- RESET:
  - proj_ena[cur_addr] = 1, all other bits 0; iw_out[1] forced 0.
  - The counter decrements each cycle; at count 0, go to RUN.
  - RESET lasts exactly RST_CYCLES cycles.
- RUN:
  - proj_ena[cur_addr] = 1; iw_out[1] = iw_in[1].
  - RUN persists until a new request is accepted.
- Re-selecting the current address from RUN is legal and re-runs the full DRAIN/RESET sequence.
- Requests presented while sel_ready is 0 are ignored. The requester must hold sel_valid.
- Latency: for an accept at edge k, proj_ena rises at edge k+GUARD_CYCLES and running rises at edge k+GUARD_CYCLES+RST_CYCLES.
- proj_ena, state, cur_addr and counters are registered. proj_ena is a registered output; it never shows two bits set, not even transiently.
- active = (state == RESET || state == RUN); running = (state == RUN).
- iw_out is combinational from iw_in:
  - bits [17:2] and bit 0 (clk) pass through unchanged;
  - bit 1 = iw_in[1] && running.
  - Bit 1 is therefore 0 in IDLE, DRAIN and RESET.
- ow_out is a combinational mux: ow_in slice cur_addr when active, else 24'h0. An out-of-range cur_addr never indexes ow_in.

Test Plan:
- Reset, then select addr 3 (GUARD=2, RST=8) → proj_ena = 16'h0008 two cycles after accept; running rises 10 cycles after accept; iw_out[1] follows iw_in[1] only after that.
- In RUN on 3, select 5 → proj_ena = 0 for exactly 2 cycles, then 16'h0020; ow_out shows ow_in[143:120] once active; no cycle has two ena bits set.
- Select addr 15 with NUM_PROJ=12 → 2 DRAIN cycles, then IDLE; proj_ena = 0, active = 0, ow_out = 0.
- Hold sel_valid with addr 7 during RESET of addr 2 → sel_ready = 0 and the request is not taken; it is accepted on the first RUN cycle.
- Assert rst_n low during the 4th RESET cycle → next edge: proj_ena = 0, state IDLE, cur_addr = 0, sel_ready = 1.
- Re-select addr 3 while running 3 → ena drops for 2 cycles, then the full 8-cycle reset repeats.

Source files
------------

// File: rtl/tt_proj_mux_ctrl.sv
// tt_proj_mux_ctrl: project-select controller for the shared pad bundle
//   sel_valid/sel_ready/sel_addr : select request handshake (addr >= NUM_PROJ deselects all)
//   cur_addr                     : last accepted address
//   active/running               : a project is enabled / out of reset
//   proj_ena                     : registered one-hot ena per wrapper
//   iw_in/iw_out                 : pad bundle {uio_in, ui_in, rst_n, clk}, rst_n gated by running
//   ow_in/ow_out                 : concatenated wrapper outputs, selected {uio_oe, uio_out, uo_out}
module tt_proj_mux_ctrl #(
  parameter int NUM_PROJ     = 16,
  parameter int ADDR_W       = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int RST_CYCLES   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_valid,
  output logic                     sel_ready,
  input  logic [ADDR_W-1:0]        sel_addr,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     active,
  output logic                     running,
  output logic [NUM_PROJ-1:0]      proj_ena,
  input  logic [17:0]              iw_in,
  output logic [17:0]              iw_out,
  input  logic [24*NUM_PROJ-1:0]   ow_in,
  output logic [23:0]              ow_out
);
  localparam int CW = $clog2((GUARD_CYCLES > RST_CYCLES ? GUARD_CYCLES : RST_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, RESET, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [NUM_PROJ-1:0] ena_nx;
  logic in_range;
  assign in_range  = 32'(cur_addr) < NUM_PROJ;
  assign sel_ready = state == IDLE || state == RUN;
  assign active    = state == RESET || state == RUN;
  assign running   = state == RUN;
  assign iw_out    = {iw_in[17:2], iw_in[1] & running, iw_in[0]};
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = cur_addr;
    case (state)
      IDLE, RUN: if (sel_valid) begin
        addr_nx  = sel_addr;
        state_nx = DRAIN;
        cnt_nx   = CW'(GUARD_CYCLES - 1);
      end
      DRAIN: if (cnt == '0) begin
        state_nx = in_range ? RESET : IDLE;
        cnt_nx   = in_range ? CW'(RST_CYCLES - 1) : '0;
      end else cnt_nx = cnt - CW'(1);
      RESET: if (cnt == '0) state_nx = RUN;
        else cnt_nx = cnt - CW'(1);
      default: ;
    endcase
    // ena is registered from the next state so it drops on the accept edge itself
    ena_nx = (state_nx == RESET || state_nx == RUN) ? NUM_PROJ'(1) << addr_nx : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_addr <= '0;
      proj_ena <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_addr <= addr_nx;
      proj_ena <= ena_nx;
    end
  end
  // compare against in-range constants only, so an out-of-range address never indexes ow_in
  always_comb begin
    ow_out = '0;
    for (int i = 0; i < NUM_PROJ; i++)
      if (active && cur_addr == ADDR_W'(i)) ow_out = ow_in[24*i +: 24];
  end
endmodule
